// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with one-hot write decode, bypassed read ports and busy scoreboard
module regfile_sb #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   output logic [(1<<ADDR_W)-1:0]   wr_sel_o,
   input  logic [ADDR_W-1:0]        rd0_addr_i,
   input  logic [ADDR_W-1:0]        rd1_addr_i,
   output logic [DATA_W-1:0]        rd0_data_o,
   output logic [DATA_W-1:0]        rd1_data_o,
   output logic                     rd0_busy_o,
   output logic                     rd1_busy_o,
   input  logic                     issue_en_i,
   input  logic [ADDR_W-1:0]        issue_dest_i,
   output logic                     issue_ready_o,
   output logic [(1<<ADDR_W)-1:0]   busy_o
);

   localparam int NUM_REGS = 1 << ADDR_W;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] sel;
   logic [NUM_REGS-1:0] sel_q;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_set;
   logic [NUM_REGS-1:0] busy_next;
   logic                hit0;
   logic                hit1;
   logic                accept;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_REG && (a == '0);
   endfunction

   always_comb begin
      sel = '0;
      if (wr_en_i) sel[wr_addr_i] = 1'b1;
      if (ZERO_REG) sel[0] = 1'b0;
   end

   // Bypass is suppressed while in reset so reads show the stored (cleared) state.
   assign hit0 = rst_ni & wr_en_i & (wr_addr_i == rd0_addr_i) & ~is_zero(rd0_addr_i);
   assign hit1 = rst_ni & wr_en_i & (wr_addr_i == rd1_addr_i) & ~is_zero(rd1_addr_i);

   always_comb begin
      rd0_data_o = regs_q[rd0_addr_i];
      if (is_zero(rd0_addr_i)) rd0_data_o = '0;
      else if (hit0)           rd0_data_o = wr_data_i;
   end

   always_comb begin
      rd1_data_o = regs_q[rd1_addr_i];
      if (is_zero(rd1_addr_i)) rd1_data_o = '0;
      else if (hit1)           rd1_data_o = wr_data_i;
   end

   assign rd0_busy_o = rst_ni & busy_q[rd0_addr_i] & ~hit0;
   assign rd1_busy_o = rst_ni & busy_q[rd1_addr_i] & ~hit1;

   assign issue_ready_o = rst_ni &
                          (~busy_q[issue_dest_i] | (wr_en_i & (wr_addr_i == issue_dest_i)));
   assign accept = issue_en_i & issue_ready_o;

   // A new reservation overrides a same-cycle release of the same register.
   always_comb begin
      busy_set = '0;
      if (accept) busy_set[issue_dest_i] = 1'b1;
      if (ZERO_REG) busy_set[0] = 1'b0;
      busy_next = busy_set | (busy_q & ~sel);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
         busy_q <= '0;
         sel_q  <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (sel[k]) regs_q[k] <= wr_data_i;
         end
         busy_q <= busy_next;
         sel_q  <= sel;
      end
   end

   assign wr_sel_o = sel_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed vector bench for regfile_sb
module tb_regfile_sb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] rd0_addr, rd1_addr;
   logic       issue_en;
   logic [2:0] issue_dest;

   logic [7:0] wr_sel, busy, rd0_data, rd1_data;
   logic       rd0_busy, rd1_busy, issue_ready;
   logic [7:0] z_wr_sel, z_busy, z_rd0_data, z_rd1_data;
   logic       z_rd0_busy, z_rd1_busy, z_issue_ready;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_sel_o(wr_sel), .rd0_addr_i(rd0_addr), .rd1_addr_i(rd1_addr),
      .rd0_data_o(rd0_data), .rd1_data_o(rd1_data), .rd0_busy_o(rd0_busy), .rd1_busy_o(rd1_busy),
      .issue_en_i(issue_en), .issue_dest_i(issue_dest), .issue_ready_o(issue_ready), .busy_o(busy)
   );

   regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) dut_z (
      .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_sel_o(z_wr_sel), .rd0_addr_i(rd0_addr), .rd1_addr_i(rd1_addr),
      .rd0_data_o(z_rd0_data), .rd1_data_o(z_rd1_data), .rd0_busy_o(z_rd0_busy), .rd1_busy_o(z_rd1_busy),
      .issue_en_i(issue_en), .issue_dest_i(issue_dest), .issue_ready_o(z_issue_ready), .busy_o(z_busy)
   );

   typedef struct {
      logic       rst_n;
      logic       wr_en;
      logic [2:0] wr_addr;
      logic [7:0] wr_data;
      logic [2:0] rd0_addr;
      logic [2:0] rd1_addr;
      logic       issue_en;
      logic [2:0] issue_dest;
      logic [7:0] e_rd0;
      logic [7:0] e_rd1;
      logic       e_b0;
      logic       e_b1;
      logic       e_rdy;
      logic [7:0] e_busy;
      logic [7:0] e_sel;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] a0, input logic [2:0] a1, input logic ie, input logic [2:0] id,
                      input logic [7:0] d0, input logic [7:0] d1, input logic b0, input logic b1,
                      input logic rdy, input logic [7:0] bz, input logic [7:0] sl);
      vec_t v;
      v.rst_n = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
      v.rd0_addr = a0; v.rd1_addr = a1; v.issue_en = ie; v.issue_dest = id;
      v.e_rd0 = d0; v.e_rd1 = d1; v.e_b0 = b0; v.e_b1 = b1; v.e_rdy = rdy;
      v.e_busy = bz; v.e_sel = sl;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic we, input logic [2:0] wa, input logic [7:0] wd,
                        input logic [2:0] a0, input logic [2:0] a1, input logic ie, input logic [2:0] id);
      rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
      rd0_addr = a0; rd1_addr = a1; issue_en = ie; issue_dest = id;
   endtask

   initial begin
      //   rst we wa  wd     a0 a1 ie id   rd0    rd1    b0 b1 rdy busy   sel
      add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00);
      add(1, 0, 0, 8'h00, 2, 3, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00);
      add(1, 0, 0, 8'h00, 4, 5, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00);
      add(1, 0, 0, 8'h00, 6, 7, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00);
      add(1, 1, 3, 8'hA5, 3, 4, 0, 0, 8'hA5, 8'h00, 0, 0, 1, 8'h00, 8'h08);
      add(1, 0, 0, 8'h00, 3, 3, 0, 0, 8'hA5, 8'hA5, 0, 0, 1, 8'h00, 8'h00);
      add(1, 0, 0, 8'h00, 3, 5, 1, 5, 8'hA5, 8'h00, 0, 0, 1, 8'h20, 8'h00);
      add(1, 0, 0, 8'h00, 3, 5, 1, 5, 8'hA5, 8'h00, 0, 1, 0, 8'h20, 8'h00);
      add(1, 1, 5, 8'h3C, 5, 5, 0, 5, 8'h3C, 8'h3C, 0, 0, 1, 8'h00, 8'h20);
      add(1, 0, 0, 8'h00, 2, 5, 1, 2, 8'h00, 8'h3C, 0, 0, 1, 8'h04, 8'h00);
      add(1, 1, 2, 8'h5A, 2, 2, 1, 2, 8'h5A, 8'h5A, 0, 0, 1, 8'h04, 8'h04);
      add(1, 0, 0, 8'h00, 2, 2, 0, 2, 8'h5A, 8'h5A, 1, 1, 0, 8'h04, 8'h00);
      add(1, 1, 2, 8'h77, 2, 3, 0, 0, 8'h77, 8'hA5, 0, 0, 1, 8'h00, 8'h04);
      add(1, 1, 7, 8'hC3, 2, 7, 0, 0, 8'h77, 8'hC3, 0, 0, 1, 8'h00, 8'h80);
      add(1, 0, 0, 8'h00, 1, 7, 1, 1, 8'h00, 8'hC3, 0, 0, 1, 8'h02, 8'h00);
      add(1, 0, 0, 8'h00, 6, 1, 1, 6, 8'h00, 8'h00, 0, 1, 1, 8'h42, 8'h00);
      add(1, 1, 4, 8'h11, 4, 1, 0, 6, 8'h11, 8'h00, 0, 1, 0, 8'h42, 8'h10);
      add(0, 1, 4, 8'h99, 4, 6, 1, 3, 8'h11, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      add(1, 0, 0, 8'h00, 4, 3, 0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00);
      add(1, 1, 6, 8'hEE, 6, 1, 0, 0, 8'hEE, 8'h00, 0, 0, 1, 8'h00, 8'h40);

      drive(0, 0, 0, 8'h00, 0, 0, 1, 0);
      @(posedge clk);
      #2;
      check("reset issue_ready", issue_ready, 1'b0);
      check("reset z_issue_ready", z_issue_ready, 1'b0);
      @(posedge clk);
      #1;
      check("reset busy_o", busy, 8'h00);
      check("reset wr_sel_o", wr_sel, 8'h00);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst_n, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data,
               vecs[i].rd0_addr, vecs[i].rd1_addr, vecs[i].issue_en, vecs[i].issue_dest);
         #2;
         check($sformatf("v%0d rd0_data", i), rd0_data, vecs[i].e_rd0);
         check($sformatf("v%0d rd1_data", i), rd1_data, vecs[i].e_rd1);
         check($sformatf("v%0d rd0_busy", i), rd0_busy, vecs[i].e_b0);
         check($sformatf("v%0d rd1_busy", i), rd1_busy, vecs[i].e_b1);
         check($sformatf("v%0d issue_ready", i), issue_ready, vecs[i].e_rdy);
         @(posedge clk);
         #1;
         check($sformatf("v%0d busy_o", i), busy, vecs[i].e_busy);
         check($sformatf("v%0d wr_sel_o", i), wr_sel, vecs[i].e_sel);
      end

      // Register 0: ordinary on dut, hardwired zero on dut_z.
      @(negedge clk);
      drive(1, 1, 0, 8'hFF, 0, 6, 0, 0);
      #2;
      check("r0 bypass plain", rd0_data, 8'hFF);
      check("r0 bypass zero", z_rd0_data, 8'h00);
      check("r6 z stored", z_rd1_data, 8'hEE);
      @(posedge clk);
      #1;
      check("r0 wr_sel plain", wr_sel, 8'h01);
      check("r0 wr_sel zero", z_wr_sel, 8'h00);
      @(negedge clk);
      drive(1, 0, 0, 8'h00, 0, 0, 1, 0);
      #2;
      check("r0 stored plain", rd0_data, 8'hFF);
      check("r0 stored zero", z_rd0_data, 8'h00);
      check("r0 issue_ready zero", z_issue_ready, 1'b1);
      @(posedge clk);
      #1;
      check("r0 busy plain", busy, 8'h01);
      check("r0 busy zero", z_busy, 8'h00);
      @(negedge clk);
      drive(1, 0, 0, 8'h00, 0, 0, 1, 0);
      #2;
      check("r0 reissue ready plain", issue_ready, 1'b0);
      check("r0 reissue ready zero", z_issue_ready, 1'b1);
      check("r0 rd0_busy plain", rd0_busy, 1'b1);
      check("r0 rd0_busy zero", z_rd0_busy, 1'b0);
      @(posedge clk);
      #1;
      check("r0 busy zero after reissue", z_busy, 8'h00);
      @(negedge clk);
      drive(1, 0, 0, 8'h00, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
